// File: rtl/sigma_irq_pkg.sv
// Shared constants for the sigma interrupt controller: CSR offsets, MODE encoding, channel limit.
package sigma_irq_pkg;

    localparam int IRQ_MAX_CHANNELS = 32;

    localparam logic [4:0] IRQ_ENABLE_ADDR  = 5'h00;
    localparam logic [4:0] IRQ_PENDING_ADDR = 5'h04;
    localparam logic [4:0] IRQ_MODE_ADDR    = 5'h08;
    localparam logic [4:0] IRQ_LEVEL_ADDR   = 5'h0C;
    localparam logic [4:0] IRQ_ID_ADDR      = 5'h10;

    localparam logic IRQ_MODE_LEVEL = 1'b0;
    localparam logic IRQ_MODE_EDGE  = 1'b1;

endpackage

// File: rtl/sigma_irq_if.sv
// sigma CSR bus: single-cycle request, ack and read data one cycle later.
interface sigma_irq_if;
    logic        req;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, we, addr, wdata, input ack, rdata);
    modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/sigma_irq_debouncer.sv
// One-channel debouncer: db follows the input after 2^DEBOUNCER_FACTOR_POW stable cycles.
module sigma_irq_debouncer #(
    parameter int DEBOUNCER_FACTOR_POW = 2
) (
    input  logic clk_i,
    input  logic arst_i,
    input  logic src_i,
    output logic db_o,
    output logic db_nxt_o
);
    localparam logic [DEBOUNCER_FACTOR_POW-1:0] ONE = DEBOUNCER_FACTOR_POW'(1);

    logic [DEBOUNCER_FACTOR_POW-1:0] cnt_q, cnt_d;
    logic db_q, db_d;

    always_comb begin
        cnt_d = '0;
        db_d  = db_q;
        if (src_i != db_q) begin
            if (&cnt_q) db_d = ~db_q;
            else        cnt_d = cnt_q + ONE;
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            cnt_q <= '0;
            db_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            db_q  <= db_d;
        end
    end

    assign db_o     = db_q;
    assign db_nxt_o = db_d;
endmodule

// File: rtl/sigma_irq_ctrl.sv
// Multi-channel debounced interrupt controller on the sigma CSR bus.
// Define SIGMA_IRQ_SYNC_EN to add a 2-flop input synchroniser ahead of the debouncers.
module sigma_irq_ctrl
    import sigma_irq_pkg::*;
#(
    parameter int          CHANNELS             = 8,
    parameter int          DEBOUNCER_FACTOR_POW = 2,
    parameter logic [31:0] RESET_ENABLE         = 32'h0
) (
    input  logic                clk_i,
    input  logic                arst_i,
    input  logic [CHANNELS-1:0] irq_src_i,
    sigma_irq_if.slave          bus,
    output logic                irq_o,
    output logic [4:0]          irq_id_o
);
    logic [CHANNELS-1:0] src_db_in, level, level_nxt, rise;
    logic [CHANNELS-1:0] en_q, en_d, mode_q, mode_d, pend_q, pend_d, clr, act;
    logic                irq_q, irq_d, ack_q;
    logic [4:0]          id_q, id_d;
    logic [31:0]         rdata_q, rdata_d, rd_val;
    logic                wr, rd;
    logic                unused_bits;

`ifdef SIGMA_IRQ_SYNC_EN
    logic [CHANNELS-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= irq_src_i;
            sync2_q <= sync1_q;
        end
    end
    assign src_db_in = sync2_q;
`else
    assign src_db_in = irq_src_i;
`endif

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        sigma_irq_debouncer #(.DEBOUNCER_FACTOR_POW(DEBOUNCER_FACTOR_POW)) u_db (
            .clk_i    (clk_i),
            .arst_i   (arst_i),
            .src_i    (src_db_in[g]),
            .db_o     (level[g]),
            .db_nxt_o (level_nxt[g])
        );
    end

    // Capture uses the debouncer's next level so level-mode pending tracks db exactly.
    assign rise = level_nxt & ~level;
    assign wr   = bus.req & bus.we;
    assign rd   = bus.req & ~bus.we;

    always_comb begin
        en_d   = en_q;
        mode_d = mode_q;
        clr    = '0;
        if (wr) begin
            case (bus.addr[4:2])
                IRQ_ENABLE_ADDR[4:2]:  en_d   = bus.wdata[CHANNELS-1:0];
                IRQ_PENDING_ADDR[4:2]: clr    = bus.wdata[CHANNELS-1:0];
                IRQ_MODE_ADDR[4:2]:    mode_d = bus.wdata[CHANNELS-1:0];
                default: ;
            endcase
        end
        for (int i = 0; i < CHANNELS; i++) begin
            if (mode_q[i] == IRQ_MODE_EDGE) pend_d[i] = (pend_q[i] & ~clr[i]) | rise[i];
            else                            pend_d[i] = level_nxt[i];
        end
    end

    // Descending scan leaves the lowest active index in id_d.
    always_comb begin
        act   = pend_q & en_q;
        irq_d = |act;
        id_d  = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (act[i]) id_d = 5'(i);
        end
    end

    always_comb begin
        rd_val = '0;
        case (bus.addr[4:2])
            IRQ_ENABLE_ADDR[4:2]:  rd_val = 32'(en_q);
            IRQ_PENDING_ADDR[4:2]: rd_val = 32'(pend_q);
            IRQ_MODE_ADDR[4:2]:    rd_val = 32'(mode_q);
            IRQ_LEVEL_ADDR[4:2]:   rd_val = 32'(level);
            IRQ_ID_ADDR[4:2]:      rd_val = {irq_q, 26'b0, id_q};
            default: ;
        endcase
        rdata_d = rd ? rd_val : '0;
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            en_q    <= RESET_ENABLE[CHANNELS-1:0];
            mode_q  <= '0;
            pend_q  <= '0;
            irq_q   <= 1'b0;
            id_q    <= '0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            en_q    <= en_d;
            mode_q  <= mode_d;
            pend_q  <= pend_d;
            irq_q   <= irq_d;
            id_q    <= id_d;
            ack_q   <= bus.req;
            rdata_q <= rdata_d;
        end
    end

    assign bus.ack     = ack_q;
    assign bus.rdata   = rdata_q;
    assign irq_o       = irq_q;
    assign irq_id_o    = id_q;
    assign unused_bits = ^{bus.addr[1:0], bus.wdata};
endmodule

// File: tb/tb_sigma_irq_ctrl.sv
// Bench for sigma_irq_ctrl: directed scenarios plus random traffic against a window-based model.
module tb_sigma_irq_ctrl;
    import sigma_irq_pkg::*;

    localparam int          CH     = 8;
    localparam int          POW    = 2;
    localparam int          WIN    = 1 << POW;
    localparam logic [31:0] RST_EN = 32'h0;
`ifdef SIGMA_IRQ_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif

    logic          clk  = 1'b0;
    logic          arst = 1'b1;
    logic [CH-1:0] src  = '0;
    logic          irq;
    logic [4:0]    irq_id;
    int            checks = 0;
    int            errors = 0;

    sigma_irq_if bus();

    sigma_irq_ctrl #(.CHANNELS(CH), .DEBOUNCER_FACTOR_POW(POW), .RESET_ENABLE(RST_EN)) dut (
        .clk_i     (clk),
        .arst_i    (arst),
        .irq_src_i (src),
        .bus       (bus),
        .irq_o     (irq),
        .irq_id_o  (irq_id)
    );

    always #5 clk = ~clk;

    // Reference: db toggles once the last WIN sampled inputs all disagree with it.
    typedef struct packed {
        logic [CH-1:0]          s1, s2, db, pend, en, mode;
        logic [CH-1:0][WIN-1:0] hist;
        logic                   irq;
        logic [4:0]             id;
        logic                   ack;
        logic [31:0]            rdata;
    } model_t;

    model_t m;

    function automatic model_t model_reset();
        model_t r = '0;
        r.en = RST_EN[CH-1:0];
        return r;
    endfunction

    function automatic model_t model_step(model_t s, logic [CH-1:0] in, logic req, logic we,
                                          logic [4:0] addr, logic [31:0] wdata);
        model_t        n = s;
        logic [CH-1:0] din, clr, act;
        logic [31:0]   rv;
        logic [2:0]    word = addr[4:2];
        din  = (SYNC != 0) ? s.s2 : in;
        n.s1 = in;
        n.s2 = s.s1;
        for (int c = 0; c < CH; c++) begin
            n.hist[c] = {s.hist[c][WIN-2:0], din[c]};
            n.db[c]   = (n.hist[c] == {WIN{~s.db[c]}}) ? ~s.db[c] : s.db[c];
        end
        case (word)
            3'd0:    rv = 32'(s.en);
            3'd1:    rv = 32'(s.pend);
            3'd2:    rv = 32'(s.mode);
            3'd3:    rv = 32'(s.db);
            3'd4:    rv = {s.irq, 26'b0, s.id};
            default: rv = 32'h0;
        endcase
        clr = '0;
        if (req && we) begin
            case (word)
                3'd0:    n.en   = wdata[CH-1:0];
                3'd1:    clr    = wdata[CH-1:0];
                3'd2:    n.mode = wdata[CH-1:0];
                default: ;
            endcase
        end
        for (int c = 0; c < CH; c++)
            n.pend[c] = s.mode[c] ? ((s.pend[c] & ~clr[c]) | (n.db[c] & ~s.db[c])) : n.db[c];
        act   = s.pend & s.en;
        n.irq = |act;
        n.id  = '0;
        for (int c = 0; c < CH; c++) begin
            if (act[c]) begin
                n.id = 5'(c);
                break;
            end
        end
        n.ack   = req;
        n.rdata = (req && !we) ? rv : 32'h0;
        return n;
    endfunction

    always @(posedge clk or posedge arst) begin
        if (arst) m <= model_reset();
        else      m <= model_step(m, src, bus.req, bus.we, bus.addr, bus.wdata);
    end

    // Bus tasks start and end on a falling edge.
    task automatic csr_write(input logic [4:0] a, input logic [31:0] d);
        bus.req = 1'b1; bus.we = 1'b1; bus.addr = a; bus.wdata = d;
        @(negedge clk);
        bus.req = 1'b0; bus.we = 1'b0;
    endtask

    task automatic csr_read(input logic [4:0] a, output logic [31:0] d);
        bus.req = 1'b1; bus.we = 1'b0; bus.addr = a;
        @(negedge clk);
        d = bus.ack ? bus.rdata : 32'hxxxxxxxx;
        bus.req = 1'b0;
    endtask

    task automatic do_reset();
        src = '0; bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
        arst = 1'b1;
        repeat (2) @(negedge clk);
        arst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] v;
        logic [4:0]  addrs [5] = '{IRQ_ENABLE_ADDR, IRQ_PENDING_ADDR, IRQ_MODE_ADDR, IRQ_LEVEL_ADDR, IRQ_ID_ADDR};
        logic [31:0] exps  [5] = '{32'(RST_EN[CH-1:0]), 32'h0, 32'h0, 32'h0, 32'h0};
        do_reset();
        checks++; if (bus.ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", bus.ack); end
        checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", bus.rdata); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq); end
        checks++; if (irq_id !== 5'd0) begin errors++; $display("FAIL reset_id: got %0d want 0", irq_id); end
        for (int i = 0; i < 5; i++) begin
            csr_read(addrs[i], v);
            checks++;
            if (v !== exps[i]) begin errors++; $display("FAIL reset_reg_%h: got %h want %h", addrs[i], v, exps[i]); end
        end
    endtask

    task automatic test_debounce();
        logic [31:0] v;
        do_reset();
        csr_write(IRQ_MODE_ADDR, 32'h1);
        csr_write(IRQ_ENABLE_ADDR, 32'h1);
        src[0] = 1'b1;
        repeat (SYNC + 3) @(negedge clk);
        csr_read(IRQ_LEVEL_ADDR, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL debounce_early_level: got %h want 0", v); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL debounce_early_irq: got %b want 0", irq); end
        csr_read(IRQ_LEVEL_ADDR, v);
        checks++; if (v !== 32'h1) begin errors++; $display("FAIL debounce_level: got %h want 1", v); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL debounce_irq: got %b want 1", irq); end
        checks++; if (irq_id !== 5'd0) begin errors++; $display("FAIL debounce_id: got %0d want 0", irq_id); end
        csr_read(IRQ_PENDING_ADDR, v);
        checks++; if (v !== 32'h1) begin errors++; $display("FAIL debounce_pending: got %h want 1", v); end
    endtask

    task automatic test_glitch();
        logic [31:0] v;
        do_reset();
        csr_write(IRQ_MODE_ADDR, 32'hFF);
        csr_write(IRQ_ENABLE_ADDR, 32'hFF);
        src[2] = 1'b1;
        repeat (3) @(negedge clk);
        src[2] = 1'b0;
        repeat (SYNC + 8) @(negedge clk);
        csr_read(IRQ_LEVEL_ADDR, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL glitch_level: got %h want 0", v); end
        csr_read(IRQ_PENDING_ADDR, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL glitch_pending: got %h want 0", v); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL glitch_irq: got %b want 0", irq); end
    endtask

    task automatic test_priority();
        logic [31:0] v;
        do_reset();
        csr_write(IRQ_MODE_ADDR, 32'h28);
        csr_write(IRQ_ENABLE_ADDR, 32'h28);
        src = 8'h28;
        repeat (SYNC + 6) @(negedge clk);
        csr_read(IRQ_ID_ADDR, v);
        checks++; if (v !== 32'h80000003) begin errors++; $display("FAIL priority_both: got %h want 80000003", v); end
        csr_write(IRQ_PENDING_ADDR, 32'h08);
        @(negedge clk);
        csr_read(IRQ_ID_ADDR, v);
        checks++; if (v !== 32'h80000005) begin errors++; $display("FAIL priority_ch5: got %h want 80000005", v); end
        csr_write(IRQ_PENDING_ADDR, 32'h20);
        @(negedge clk);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL priority_irq_off: got %b want 0", irq); end
        csr_read(IRQ_ID_ADDR, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL priority_none: got %h want 0", v); end
    endtask

    task automatic test_level_mask();
        logic [31:0] v;
        do_reset();
        src[1] = 1'b1;
        repeat (SYNC + 5) @(negedge clk);
        csr_read(IRQ_PENDING_ADDR, v);
        checks++; if (v !== 32'h2) begin errors++; $display("FAIL level_pending: got %h want 2", v); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL level_masked_irq: got %b want 0", irq); end
        csr_write(IRQ_ENABLE_ADDR, 32'h2);
        @(negedge clk);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL level_unmasked_irq: got %b want 1", irq); end
        checks++; if (irq_id !== 5'd1) begin errors++; $display("FAIL level_id: got %0d want 1", irq_id); end
        csr_write(IRQ_PENDING_ADDR, 32'h2);
        csr_read(IRQ_PENDING_ADDR, v);
        checks++; if (v !== 32'h2) begin errors++; $display("FAIL level_w1c_ignored: got %h want 2", v); end
        src[1] = 1'b0;
        repeat (SYNC + 4) @(negedge clk);
        csr_read(IRQ_PENDING_ADDR, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL level_drop: got %h want 0", v); end
    endtask

    task automatic test_collision();
        logic [31:0] v;
        do_reset();
        csr_write(IRQ_MODE_ADDR, 32'h1);
        csr_write(IRQ_ENABLE_ADDR, 32'h1);
        src[0] = 1'b1;
        repeat (SYNC + 3) @(negedge clk);
        csr_write(IRQ_PENDING_ADDR, 32'h1);
        csr_read(IRQ_PENDING_ADDR, v);
        checks++; if (v !== 32'h1) begin errors++; $display("FAIL collision_set_wins: got %h want 1", v); end
        csr_write(IRQ_PENDING_ADDR, 32'h1);
        csr_read(IRQ_PENDING_ADDR, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL collision_later_clear: got %h want 0", v); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] v;
        do_reset();
        bus.req = 1'b1; bus.we = 1'b1; bus.addr = IRQ_ENABLE_ADDR; bus.wdata = 32'hFF;
        @(negedge clk);
        checks++; if (bus.ack !== 1'b1) begin errors++; $display("FAIL b2b_ack_w0: got %b want 1", bus.ack); end
        bus.addr = IRQ_MODE_ADDR; bus.wdata = 32'h0F;
        @(negedge clk);
        checks++; if (bus.ack !== 1'b1) begin errors++; $display("FAIL b2b_ack_w1: got %b want 1", bus.ack); end
        bus.we = 1'b0; bus.addr = IRQ_ENABLE_ADDR;
        @(negedge clk);
        checks++; if (bus.ack !== 1'b1 || bus.rdata !== 32'hFF) begin
            errors++; $display("FAIL b2b_read_en: got ack %b data %h want ack 1 data ff", bus.ack, bus.rdata); end
        bus.addr = 5'h14;
        @(negedge clk);
        checks++; if (bus.ack !== 1'b1 || bus.rdata !== 32'h0) begin
            errors++; $display("FAIL b2b_read_unmapped: got ack %b data %h want ack 1 data 0", bus.ack, bus.rdata); end
        bus.we = 1'b1; bus.addr = 5'h14; bus.wdata = 32'hFFFF_FFFF;
        @(negedge clk);
        checks++; if (bus.ack !== 1'b1 || bus.rdata !== 32'h0) begin
            errors++; $display("FAIL b2b_write_unmapped: got ack %b data %h want ack 1 data 0", bus.ack, bus.rdata); end
        bus.req = 1'b0; bus.we = 1'b0;
        @(negedge clk);
        checks++; if (bus.ack !== 1'b0) begin errors++; $display("FAIL b2b_idle_ack: got %b want 0", bus.ack); end
        csr_read(IRQ_MODE_ADDR, v);
        checks++; if (v !== 32'h0F) begin errors++; $display("FAIL b2b_mode: got %h want 0f", v); end
        csr_read(IRQ_ENABLE_ADDR, v);
        checks++; if (v !== 32'hFF) begin errors++; $display("FAIL b2b_enable_kept: got %h want ff", v); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        src[0] = 1'b1;
        repeat (SYNC + 6) @(negedge clk);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL rstmid_pre_irq: got %b want 1", irq); end
        bus.req = 1'b1; bus.we = 1'b0; bus.addr = IRQ_ENABLE_ADDR;
        #2 arst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if (bus.ack !== 1'b0) begin errors++; $display("FAIL rstmid_ack_%0d: got %b want 0", i, bus.ack); end
        end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rstmid_irq: got %b want 0", irq); end
        bus.req = 1'b0; arst = 1'b0; src = '0;
        @(negedge clk);
        checks++; if (bus.ack !== 1'b0) begin errors++; $display("FAIL rstmid_ack_after: got %b want 0", bus.ack); end
        csr_read(IRQ_ENABLE_ADDR, v);
        checks++; if (v !== 32'(RST_EN[CH-1:0])) begin errors++; $display("FAIL rstmid_enable: got %h want %h", v, RST_EN); end
        csr_read(IRQ_MODE_ADDR, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL rstmid_mode: got %h want 0", v); end
        csr_read(IRQ_PENDING_ADDR, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL rstmid_pending: got %h want 0", v); end
        csr_read(IRQ_LEVEL_ADDR, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL rstmid_level: got %h want 0", v); end
    endtask

    task automatic test_random();
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            arst = ($urandom_range(0, 499) == 0);
            for (int c = 0; c < CH; c++)
                if ($urandom_range(0, 11) == 0) src[c] = ~src[c];
            bus.req   = 1'($urandom_range(0, 1));
            bus.we    = ($urandom_range(0, 2) == 0);
            bus.addr  = 5'($urandom_range(0, 31));
            bus.wdata = $urandom();
            @(negedge clk);
            checks++;
            if (bus.ack !== m.ack || bus.rdata !== m.rdata || irq !== m.irq || irq_id !== m.id) begin
                errors++;
                $display("FAIL random_cyc%0d: got ack %b rdata %h irq %b id %0d, want ack %b rdata %h irq %b id %0d",
                         cyc, bus.ack, bus.rdata, irq, irq_id, m.ack, m.rdata, m.irq, m.id);
            end
        end
        arst = 1'b0; bus.req = 1'b0;
    endtask

    initial begin
        bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
        test_reset();
        test_debounce();
        test_glitch();
        test_priority();
        test_level_mask();
        test_collision();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
